// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and default widths for the DC sweep sequencer
package sweep_pkg;

  localparam int DAC_W_DEF    = 12;
  localparam int ADC_W_DEF    = 12;
  localparam int NPTS_W_DEF   = 10;
  localparam int SETTLE_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CONVERT,
    ST_EMIT,
    ST_DONE
  } sweep_state_e;

  typedef struct packed {
    logic [NPTS_W_DEF-1:0] index;
    logic [DAC_W_DEF-1:0]  code;
    logic [ADC_W_DEF-1:0]  sample;
  } sweep_rec_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable saturating down-counter with a zero flag
module sweep_settle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// rtl/sweep_sequencer.sv - DC sweep controller: load DAC code, settle, convert, emit record
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int DAC_W    = DAC_W_DEF,
  parameter int ADC_W    = ADC_W_DEF,
  parameter int NPTS_W   = NPTS_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DAC_W-1:0]    cfg_start_code,
  input  logic [DAC_W-1:0]    cfg_step_code,
  input  logic [NPTS_W-1:0]   cfg_num_points,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic                busy,
  output logic                done,
  output logic [DAC_W-1:0]    dac_code,
  output logic                dac_load,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NPTS_W-1:0]   res_index,
  output logic [DAC_W-1:0]    res_code,
  output logic [ADC_W-1:0]    res_sample
);

  sweep_state_e        state_q, state_d;
  logic [DAC_W-1:0]    step_q, step_d;
  logic [DAC_W-1:0]    dac_code_q, dac_code_d;
  logic [NPTS_W-1:0]   num_q, num_d;
  logic [NPTS_W-1:0]   idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  sweep_rec_t          rec_q, rec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dac_load_q, dac_load_d;
  logic                adc_req_q, adc_req_d;
  logic                res_valid_q, res_valid_d;

  logic                timer_load;
  logic                timer_zero;
  logic [SETTLE_W-1:0] timer_val;

  // SETTLE is skipped entirely for settle==0, so the counter only needs settle-1.
  assign timer_load = (state_q == ST_LOAD);
  assign timer_val  = settle_q - SETTLE_W'(1);

  sweep_settle_timer #(
    .W(SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dac_code_d = dac_code_q;
    num_d      = num_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    rec_d      = rec_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            step_d   = cfg_step_code;
            num_d    = cfg_num_points;
            settle_d = cfg_settle;
            idx_d    = '0;
            if (cfg_num_points == '0) begin
              state_d = ST_DONE;
            end else begin
              dac_code_d = cfg_start_code;
              state_d    = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          state_d = (settle_q == '0) ? ST_CONVERT : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_zero) begin
            state_d = ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (adc_ack) begin
            rec_d.index  = idx_q;
            rec_d.code   = dac_code_q;
            rec_d.sample = adc_data;
            state_d      = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            if (idx_q == num_q - NPTS_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d      = idx_q + NPTS_W'(1);
              dac_code_d = dac_code_q + step_q;
              state_d    = ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    dac_load_d  = (state_d == ST_LOAD);
    adc_req_d   = (state_d == ST_CONVERT);
    res_valid_d = (state_d == ST_EMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      dac_code_q  <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      settle_q    <= '0;
      rec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dac_load_q  <= 1'b0;
      adc_req_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dac_code_q  <= dac_code_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      rec_q       <= rec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dac_load_q  <= dac_load_d;
      adc_req_q   <= adc_req_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dac_code   = dac_code_q;
  assign dac_load   = dac_load_q;
  assign adc_req    = adc_req_q;
  assign res_valid  = res_valid_q;
  assign res_index  = rec_q.index;
  assign res_code   = rec_q.code;
  assign res_sample = rec_q.sample;

endmodule
